// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register built as a two-entry skid buffer: a main entry
// drives the EX outputs, and a skid entry absorbs one instruction while EX stalls.
module id_ex_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int EX_W   = 5,
  parameter int MEM_W  = 2,
  parameter int WB_W   = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EX_W-1:0]   EX_D,
  input  logic [MEM_W-1:0]  MEM_D,
  input  logic [WB_W-1:0]   WB_D,
  input  logic [REG_W-1:0]  Rs_D,
  input  logic [REG_W-1:0]  Rt_D,
  input  logic [REG_W-1:0]  Rd_D,
  input  logic [DATA_W-1:0] RD1_D,
  input  logic [DATA_W-1:0] RD2_D,
  input  logic [DATA_W-1:0] SignImm_D,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EX_W-1:0]   EX_E,
  output logic [MEM_W-1:0]  MEM_E,
  output logic [WB_W-1:0]   WB_E,
  output logic [REG_W-1:0]  Rs_E,
  output logic [REG_W-1:0]  Rt_E,
  output logic [REG_W-1:0]  Rd_E,
  output logic [DATA_W-1:0] RD1_E,
  output logic [DATA_W-1:0] RD2_E,
  output logic [DATA_W-1:0] SignImm_E,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [EX_W-1:0]   ex;
    logic [MEM_W-1:0]  mem;
    logic [WB_W-1:0]   wb;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
  } payload_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  payload_t in_pl;
  payload_t main_pl;
  payload_t skid_pl;
  logic     main_valid;
  logic     skid_valid;
  logic     in_xfer;
  logic     main_free;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready depends only on the skid register, so there is no
  // combinational path from out_ready or in_valid to in_ready.
  assign in_pl     = {EX_D, MEM_D, WB_D, Rs_D, Rt_D, Rd_D, RD1_D, RD2_D, SignImm_D};
  assign in_ready  = !skid_valid;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = main_valid;
  // Main entry can take new content when empty or being consumed this edge.
  assign main_free = !main_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pl    <= '0;
      skid_pl    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // in_ready is low while skid is full, so no input arrives this edge.
        main_pl    <= skid_pl;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        main_pl    <= in_pl;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_pl    <= in_pl;
      skid_valid <= 1'b1;
    end
  end

  // Counts edges where EX holds an instruction it does not consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Control groups become a bubble when no instruction is held.
  assign EX_E      = main_valid ? main_pl.ex  : '0;
  assign MEM_E     = main_valid ? main_pl.mem : '0;
  assign WB_E      = main_valid ? main_pl.wb  : '0;
  assign Rs_E      = main_pl.rs;
  assign Rt_E      = main_pl.rt;
  assign Rd_E      = main_pl.rd;
  assign RD1_E     = main_pl.rd1;
  assign RD2_E     = main_pl.rd2;
  assign SignImm_E = main_pl.imm;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed scenarios then random traffic, all checked
// against a depth-2 FIFO model of the stage.
module tb_id_ex_pipe;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int EX_W   = 5;
  localparam int MEM_W  = 2;
  localparam int WB_W   = 2;
  localparam int CNT_W  = 4;
  localparam int CTRL_W = EX_W + MEM_W + WB_W;
  localparam int PW     = CTRL_W + 3 * REG_W + 3 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [EX_W-1:0]   EX_D;
  logic [MEM_W-1:0]  MEM_D;
  logic [WB_W-1:0]   WB_D;
  logic [REG_W-1:0]  Rs_D, Rt_D, Rd_D;
  logic [DATA_W-1:0] RD1_D, RD2_D, SignImm_D;
  logic              out_valid;
  logic              out_ready;
  logic [EX_W-1:0]   EX_E;
  logic [MEM_W-1:0]  MEM_E;
  logic [WB_W-1:0]   WB_E;
  logic [REG_W-1:0]  Rs_E, Rt_E, Rd_E;
  logic [DATA_W-1:0] RD1_E, RD2_E, SignImm_E;
  logic [CNT_W-1:0]  stall_cnt;
  logic [PW-1:0]     dut_pl;

  id_ex_pipe #(
    .DATA_W(DATA_W), .REG_W(REG_W), .EX_W(EX_W),
    .MEM_W(MEM_W), .WB_W(WB_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .EX_D(EX_D), .MEM_D(MEM_D), .WB_D(WB_D),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .SignImm_D(SignImm_D),
    .out_valid(out_valid), .out_ready(out_ready),
    .EX_E(EX_E), .MEM_E(MEM_E), .WB_E(WB_E),
    .Rs_E(Rs_E), .Rt_E(Rt_E), .Rd_E(Rd_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .SignImm_E(SignImm_E),
    .stall_cnt(stall_cnt)
  );

  assign dut_pl = {EX_E, MEM_E, WB_E, Rs_E, Rt_E, Rd_E, RD1_E, RD2_E, SignImm_E};

  // Clock block
  always #5 clk = ~clk;

  // Reference model: the stage is a FIFO of at most two instructions.
  logic [PW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_cnt;
  logic [PW-1:0]    last_head;
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_cnt   = '0;
    last_head = '0;
  endtask

  task automatic check_outputs();
    logic [PW-1:0] exp_pl;
    if (exp_q.size() > 0) last_head = exp_q[0];
    exp_pl = (exp_q.size() > 0) ? last_head : {{CTRL_W{1'b0}}, last_head[PW-CTRL_W-1:0]};
    chk("out_valid", out_valid, exp_q.size() > 0);
    chk("in_ready", in_ready, exp_q.size() < 2);
    chk("stall_cnt", stall_cnt, exp_cnt);
    chk("payload", dut_pl, exp_pl);
  endtask

  function automatic logic [PW-1:0] mk(input logic [EX_W-1:0] ex, input logic [DATA_W-1:0] rd1);
    logic [PW-1:0] p;
    p = {ex, MEM_W'($urandom), WB_W'($urandom), REG_W'($urandom), REG_W'($urandom),
         REG_W'($urandom), rd1, DATA_W'($urandom), DATA_W'($urandom)};
    return p;
  endfunction

  // Driver: apply inputs for one edge, advance the model, then check.
  task automatic step(input logic v, input logic [PW-1:0] pl, input logic ordy, input logic fl);
    int  pre_n;
    logic acc, pop;
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    {EX_D, MEM_D, WB_D, Rs_D, Rt_D, Rd_D, RD1_D, RD2_D, SignImm_D} = pl;
    pre_n = exp_q.size();
    acc   = v && (pre_n < 2);
    pop   = (pre_n > 0) && ordy;
    if (pre_n > 0 && !ordy && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(pl);
    end
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, ordy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [PW-1:0] p;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    {EX_D, MEM_D, WB_D, Rs_D, Rt_D, Rd_D, RD1_D, RD2_D, SignImm_D} = '0;
    model_reset();
    #12;
    check_outputs();
    chk("reset_payload", dut_pl, '0);
    rst = 1'b0;

    // Pass-through: one instruction per cycle, one-edge latency
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, mk(EX_W'($urandom), DATA_W'(i)), 1'b1, 1'b0);
      chk("pass_rd1", RD1_E, i);
    end
    idle(1'b1);

    // Back-pressure: A in main, B in skid, C refused
    step(1'b1, mk(5'h3, 32'hA), 1'b0, 1'b0);
    step(1'b1, mk(5'h4, 32'hB), 1'b0, 1'b0);
    step(1'b1, mk(5'h5, 32'hC), 1'b0, 1'b0);
    chk("bp_main", RD1_E, 32'hA);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_stall", stall_cnt, 2);
    idle(1'b1);
    chk("bp_second", RD1_E, 32'hB);
    idle(1'b1);
    chk("bp_drained", out_valid, 1'b0);

    // Bubble after an instruction with all EX control bits set
    step(1'b1, mk(5'h1F, 32'h55), 1'b1, 1'b0);
    chk("bubble_ex_live", EX_E, 5'h1F);
    idle(1'b1);
    chk("bubble_ctrl", {EX_E, MEM_E, WB_E}, '0);

    // Flush with both entries full and a new instruction offered
    step(1'b1, mk(5'h1, 32'h100), 1'b0, 1'b0);
    step(1'b1, mk(5'h2, 32'h200), 1'b0, 1'b0);
    step(1'b1, mk(5'h3, 32'h300), 1'b0, 1'b1);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    idle(1'b1);
    chk("flush_dropped", out_valid, 1'b0);

    // Stall counter saturation
    for (int i = 0; i < 20; i++) step(1'b1, mk(5'h7, DATA_W'(i)), 1'b0, 1'b0);
    chk("sat_cnt", stall_cnt, 15);
    idle(1'b1);
    idle(1'b1);
    chk("sat_hold", stall_cnt, 15);

    // Asynchronous reset between edges with both entries full
    step(1'b1, mk(5'h9, 32'hD1), 1'b0, 1'b0);
    step(1'b1, mk(5'hA, 32'hD2), 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_cnt", stall_cnt, '0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_payload", dut_pl, '0);
    in_valid = 1'b0;
    #1;
    rst = 1'b0;
    idle(1'b1);
    step(1'b1, mk(5'hB, 32'hE1), 1'b1, 1'b0);
    chk("post_rst_rd1", RD1_E, 32'hE1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      p = mk(EX_W'($urandom), $urandom);
      step(1'($urandom_range(0, 1)), p, ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
